// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between NUM_REQ burst requesters, the arbiter and a downstream sync FIFO.
interface fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          burst_trunc;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant, burst_trunc
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant, burst_trunc
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter: one requester at a time owns the FIFO write port
// until it signals last or hits MAX_BURST beats.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic          clk,
  input  logic          rst,
  fifo_wr_arb_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                state_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic [IDX_W-1:0]      owner_r;
  logic [IDX_W-1:0]      last_owner_r;
  logic [7:0]            beat_cnt_r;
  logic                  burst_trunc_r;

  logic [IDX_W-1:0]      pick_s;
  logic                  pick_vld_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  xfer_s;
  logic                  last_s;
  logic [FIFO_WIDTH-1:0] sel_data_s;

  // First valid requester scanning upward from the one after the last owner.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_v;
    pick_s     = '0;
    pick_vld_s = 1'b0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_owner_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      idx_v = IDX_W'(idx);
      if (!pick_vld_s && bus.req_valid[idx_v]) begin
        pick_s     = idx_v;
        pick_vld_s = 1'b1;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Only the owner sees ready, and never while the FIFO is full or reset is held.
  always_comb begin
    if ((state_r == ST_BURST) && !rst) begin
      ready_s = grant_r & {NUM_REQ{~bus.fifo_full}};
    end else begin
      ready_s = '0;
    end
  end

  // One-hot grant selects the owner's data lane.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = sel_data_s |
                   (bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] & {FIFO_WIDTH{grant_r[i]}});
    end
  end

  assign xfer_s           = |(bus.req_valid & ready_s);
  assign last_s           = |(bus.req_last & grant_r);
  assign bus.req_ready    = ready_s;
  assign bus.fifo_wr_en   = xfer_s;
  assign bus.fifo_wr_data = xfer_s ? sel_data_s : '0;
  assign bus.grant        = grant_r;
  assign bus.burst_trunc  = burst_trunc_r;

  // Arbitration FSM with registered grant and truncation pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      owner_r       <= '0;
      last_owner_r  <= IDX_W'(NUM_REQ - 1);
      beat_cnt_r    <= 8'd0;
      burst_trunc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          burst_trunc_r <= 1'b0;
          beat_cnt_r    <= 8'd0;
          if (pick_vld_s) begin
            grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
            owner_r <= pick_s;
            state_r <= ST_BURST;
          end else begin
            grant_r <= '0;
          end
        end
        ST_BURST: begin
          burst_trunc_r <= 1'b0;
          if (xfer_s) begin
            if (last_s) begin
              state_r      <= ST_IDLE;
              grant_r      <= '0;
              last_owner_r <= owner_r;
            end else if ((beat_cnt_r + 8'd1) == MAX_B8) begin
              state_r       <= ST_IDLE;
              grant_r       <= '0;
              last_owner_r  <= owner_r;
              burst_trunc_r <= 1'b1;
            end else begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          grant_r       <= '0;
          burst_trunc_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized and directed bench for fifo_wr_arb against a transaction-level
// model built from per-requester beat queues.
module tb_fifo_wr_arb;
  localparam int NR    = 4;
  localparam int FW    = 32;
  localparam int MB    = 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.NUM_REQ(NR), .FIFO_WIDTH(FW)) bus ();

  fifo_wr_arb #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [FW-1:0] bdata [NR][DEPTH];
  logic          blast [NR][DEPTH];
  int            head  [NR];
  int            tail  [NR];

  // model: owner of the write port (-1 when idle), beats in current burst
  int   m_owner, m_cnt, m_last;
  logic m_trunc;

  int valid_pct, full_pct, full_hold;
  int n_checks, n_errors, wr_seen, trunc_seen;
  int seq[$];
  int exp_seq[$];
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] cur_valid;
  logic          cur_full;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pending(input int r);
    return tail[r] - head[r];
  endfunction

  function automatic int total_pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pending(i);
    return s;
  endfunction

  task automatic load_beat(input int r, input logic [FW-1:0] d, input logic l);
    bdata[r][tail[r] % DEPTH] = d;
    blast[r][tail[r] % DEPTH] = l;
    tail[r]++;
  endtask

  task automatic load(input int r, input int n, input bit last_end);
    for (int j = 0; j < n; j++) load_beat(r, $urandom, last_end && (j == n - 1));
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NR - 1;
    m_trunc = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      cur_valid[i] = (pending(i) > 0) && ($urandom_range(99) < valid_pct);
      bus.req_valid[i] = cur_valid[i];
      if (pending(i) > 0) begin
        bus.req_data[i*FW +: FW] = bdata[i][head[i] % DEPTH];
        bus.req_last[i]          = blast[i][head[i] % DEPTH];
      end else begin
        bus.req_data[i*FW +: FW] = $urandom;
        bus.req_last[i]          = $urandom_range(1);
      end
    end
    if (full_hold > 0) begin
      cur_full = 1'b1;
      full_hold--;
    end else begin
      cur_full = ($urandom_range(99) < full_pct);
    end
    bus.fifo_full = cur_full;
  endtask

  task automatic step();
    logic [NR-1:0] e_ready, e_grant;
    logic          e_wr, lastb;
    logic [FW-1:0] e_data;
    bit            found;
    int            idx, gi;
    drive();
    #1;
    e_ready = '0;
    e_grant = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (!cur_full) e_ready[m_owner] = 1'b1;
      e_wr = !cur_full && cur_valid[m_owner];
      if (e_wr) e_data = bdata[m_owner][head[m_owner] % DEPTH];
    end
    check_eq("grant", bus.grant, e_grant);
    check_eq("burst_trunc", bus.burst_trunc, m_trunc);
    check_eq("req_ready", bus.req_ready, e_ready);
    check_eq("fifo_wr_en", bus.fifo_wr_en, e_wr);
    check_eq("fifo_wr_data", bus.fifo_wr_data, e_data);
    if (bus.fifo_wr_en === 1'b1) wr_seen++;
    if (bus.burst_trunc === 1'b1) trunc_seen++;
    if (bus.grant != '0 && prev_grant == '0) begin
      gi = -1;
      for (int i = 0; i < NR; i++) if (bus.grant[i]) gi = i;
      seq.push_back(gi);
    end
    prev_grant = bus.grant;
    // advance the model across the coming edge
    if (m_owner < 0) begin
      m_trunc = 1'b0;
      found   = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (!found && cur_valid[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_cnt   = 0;
        end
      end
    end else begin
      m_trunc = 1'b0;
      if (e_wr) begin
        lastb = blast[m_owner][head[m_owner] % DEPTH];
        head[m_owner]++;
        if (lastb) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_cnt + 1 == MB) begin
          m_last  = m_owner;
          m_owner = -1;
          m_trunc = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive();
    rst = 1'b1;
    #1;
    check_eq("rst grant", bus.grant, '0);
    check_eq("rst wr_en", bus.fifo_wr_en, 1'b0);
    check_eq("rst ready", bus.req_ready, '0);
    check_eq("rst trunc", bus.burst_trunc, 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst hold wr_en", bus.fifo_wr_en, 1'b0);
    check_eq("rst hold grant", bus.grant, '0);
    rst = 1'b0;
    model_reset();
    seq.delete();
    prev_grant = '0;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int c = 0;
    while (total_pending() > 0 && c < budget) begin
      step();
      c++;
    end
    check_eq({tag, " drained"}, total_pending(), 0);
  endtask

  task automatic run_until_writes(input string tag, input int n, input int budget);
    int c = 0;
    while (wr_seen < n && c < budget) begin
      step();
      c++;
    end
    check_eq({tag, " writes reached"}, wr_seen >= n, 1);
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, " grant count"}, seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < seq.size()) check_eq({tag, " grant order"}, seq[i], exp_seq[i]);
      else check_eq({tag, " grant order"}, 64'hFFFF_FFFF, exp_seq[i]);
    end
  endtask

  task automatic start(input string tag);
    seq.delete();
    wr_seen    = 0;
    trunc_seen = 0;
    valid_pct  = 100;
    full_pct   = 0;
    full_hold  = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    prev_grant    = '0;
    start("init");
    model_reset();
    @(posedge clk);
    do_reset();

    // round robin over all four, 2-beat bursts
    start("rr");
    load(0, 2, 1); load(1, 2, 1); load(2, 2, 1); load(3, 2, 1); load(0, 2, 1);
    run_until_empty("rr", 200);
    step();
    exp_seq = '{0, 1, 2, 3, 0};
    check_seq("rr");
    check_eq("rr writes", wr_seen, 10);

    // single requester, three known beats
    start("solo");
    load_beat(2, 32'h0000_000A, 1'b0);
    load_beat(2, 32'h0000_000B, 1'b0);
    load_beat(2, 32'h0000_000C, 1'b1);
    run_until_empty("solo", 50);
    step();
    exp_seq = '{2};
    check_seq("solo");
    check_eq("solo writes", wr_seen, 3);
    check_eq("solo idle grant", bus.grant, 4'b0000);

    // back-pressure mid-burst
    start("full");
    load(0, 6, 1);
    run_until_writes("full", 2, 50);
    full_hold = 5;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("full grant held", bus.grant, 4'b0001);
    end
    run_until_empty("full", 50);
    step();
    check_eq("full writes", wr_seen, 6);
    exp_seq = '{0};
    check_seq("full");

    // 10 beats with no last: cut at MAX_BURST, re-granted for the rest
    start("trunc");
    load(1, 10, 0);
    run_until_empty("trunc", 100);
    step(); step(); step();
    check_eq("trunc writes", wr_seen, 10);
    check_eq("trunc pulses", trunc_seen, 1);
    exp_seq = '{1, 1};
    check_seq("trunc");
    do_reset();

    // reset during beat 3 of requester 3, then round robin restarts at 0
    start("rstmid");
    load(3, 5, 1);
    run_until_writes("rstmid", 2, 50);
    load(0, 1, 1); load(0, 2, 1); load(2, 2, 1);
    do_reset();
    run_until_empty("rstmid", 200);
    step();
    exp_seq = '{0, 2, 3, 0};
    check_seq("rstmid");

    // random traffic with back-pressure and gaps
    start("rand");
    valid_pct = 70;
    full_pct  = 25;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 15) begin
        int r, n;
        r = $urandom_range(NR - 1);
        n = $urandom_range(12, 1);
        if (pending(r) + n < DEPTH) load(r, n, 1);
      end
      step();
    end
    valid_pct = 100;
    full_pct  = 0;
    run_until_empty("rand", 5000);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 32, giving the data width per beat.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, giving the maximum beats per grant (1..255).
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 Port req_data  input  NUM_REQ*FIFO_WIDTH  per-requester beat data; requester i in bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 Port req_last  input  NUM_REQ  per-requester last beat of burst.
REQ-009 Port req_ready  output  NUM_REQ  per-requester beat accepted this cycle when high with req_valid.
REQ-010 Port fifo_full  input  1  full flag of the downstream sync FIFO.
REQ-011 Port fifo_wr_en  output  1  write strobe to the FIFO.
REQ-012 Port fifo_wr_data  output  FIFO_WIDTH  write data to the FIFO.
REQ-013 Port grant  output  NUM_REQ  one-hot registered owner of the FIFO write port; all zero when idle.
REQ-014 Port burst_trunc  output  1  one-cycle pulse when a burst is cut at MAX_BURST without req_last.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-016 In IDLE with any req_valid high, the block SHALL select the first valid requester in round-robin order starting at (last_owner+1) mod NUM_REQ, register it into grant, clear beat_cnt and move to BURST on the next edge.
REQ-017 In IDLE with no req_valid high, the block SHALL stay in IDLE with grant all zero.
REQ-018 In BURST, req_ready[g] SHALL equal ~fifo_full for the granted requester g, combinationally; all other req_ready bits SHALL be 0; req_ready SHALL be all 0 in IDLE.
REQ-019 A beat SHALL transfer when req_valid[g] & req_ready[g]; fifo_wr_en SHALL equal that term and fifo_wr_data SHALL equal req_data of g in the same cycle (zero latency), else fifo_wr_data SHALL be 0.
REQ-020 fifo_wr_en SHALL never be high while fifo_full is high.
REQ-021 Each transfer SHALL increment beat_cnt (8-bit, no wrap within a burst).
REQ-022 A transfer with req_last[g] high SHALL end the burst: FSM to IDLE, last_owner <= g, grant <= 0.
REQ-023 A transfer with req_last[g] low and beat_cnt+1 == MAX_BURST SHALL end the burst the same way and pulse burst_trunc for the following cycle only.
REQ-024 If req_last and the MAX_BURST limit coincide, the burst SHALL end without burst_trunc.
REQ-025 req_valid[g] low or fifo_full high during BURST SHALL hold the grant and beat_cnt unchanged (no timeout).
REQ-026 At least one IDLE cycle SHALL separate consecutive bursts; a requester that just finished SHALL be granted again only if no other requester is valid.
REQ-027 Changes on non-granted req_valid/req_last/req_data SHALL have no effect during BURST.

Reset
REQ-028 While rst is high: FSM = IDLE, grant = 0, beat_cnt = 0, last_owner = NUM_REQ-1 (requester 0 wins first), burst_trunc = 0; req_ready and fifo_wr_en SHALL therefore be 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately; no beat SHALL be written in a cycle where rst is high.

Verification
REQ-030 Reset release, req_valid=4'b1111, each 2-beat bursts with last on beat 2 -> grants 0,1,2,3,0 in order, 2 writes each, one idle cycle between bursts.
REQ-031 Requester 2 alone, 3 beats A,B,C with last on C, fifo_full=0 -> fifo_wr_en high 3 cycles, fifo_wr_data A,B,C, grant=4'b0100, then grant=0.
REQ-032 Requester 1 streams 10 beats without last, MAX_BURST=8 -> 8 writes, burst_trunc one-cycle pulse, requester 1 re-granted after one IDLE cycle for remaining beats.
REQ-033 Granted requester 0 mid-burst, fifo_full held high 5 cycles -> req_ready=0, fifo_wr_en=0 for 5 cycles, grant held, burst resumes with no lost or duplicated beat.
REQ-034 rst pulsed high during beat 3 of a burst by requester 3 -> grant=0, fifo_wr_en=0 during reset; after release requester 0 wins if valid.
REQ-035 Requester 2 valid mid-burst of requester 0, req_last on beat 1 of requester 0 -> requester 2 granted next, requester 0 not re-granted while requester 2 valid.
